multicycle_sequencer: RTL and testbench

- Multicycle control FSM that sequences the MIPS datapath through FETCH/DECODE/EXEC/MEM/WB.
- Drives IR load, PC update, register-file write and data-memory strobes, with a ready handshake on data memory.
- Resolves BEQ/REGIMM/BLEZ/BGTZ/J with one architectural branch delay slot.
- Sits between the instruction register/opcode decoder and the program counter register; the PC register loads pc_next when pc_write=1.

---
 rtl/multicycle_sequencer_pkg.sv | 47 ++++
 rtl/multicycle_sequencer_branch_resolver.sv | 43 ++++
 rtl/multicycle_sequencer.sv | 165 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer:
// state encoding, opcode constants and instruction classification.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BR,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LBU      = 6'b100100;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [5:0] OP_J        = 6'b000010;

    // Map an opcode to the path it takes through the sequencer.
    function automatic instr_class_t classify(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_SPECIAL2, OP_ADDI, OP_ADDIU: classify = CLS_ALU;
            OP_LW, OP_LB, OP_LBU:                     classify = CLS_LOAD;
            OP_SW, OP_SB:                             classify = CLS_STORE;
            OP_BEQ, OP_REGIMM, OP_BLEZ, OP_BGTZ, OP_J: classify = CLS_BR;
            default:                                  classify = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_branch_resolver.sv
// Combinational branch/jump resolution: decides whether a control-transfer
// opcode is taken and computes its destination address.
module branch_resolver
    import multicycle_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jidx,
    input  logic [ADDR_W-1:0] pc,
    input  logic              rs_eq_rt,
    input  logic              rs_zero,
    input  logic              rs_neg,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_offset;

    assign pc_plus4  = pc + ADDR_W'(4);
    // Sign-extended word offset; addition wraps naturally at ADDR_W bits.
    assign br_offset = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

    // Evaluate the taken condition and select branch or jump target.
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4 + br_offset;
        case (opcode)
            OP_BEQ:    taken = rs_eq_rt;
            OP_REGIMM: taken = rs_zero;
            OP_BLEZ:   taken = rs_zero | rs_neg;
            OP_BGTZ:   taken = ~rs_zero & ~rs_neg;
            OP_J: begin
                taken  = 1'b1;
                target = {pc_plus4[ADDR_W-1:28], jidx, 2'b00};
            end
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM sequencing the MIPS datapath through
// FETCH/DECODE/EXEC/MEM/WB, with one architectural branch delay slot.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jidx,
    input  logic [ADDR_W-1:0] pc,
    input  logic              rs_eq_rt,
    input  logic              rs_zero,
    input  logic              rs_neg,
    input  logic              mem_ready,
    output logic [2:0]        state,
    output logic              ir_write,
    output logic              pc_write,
    output logic [ADDR_W-1:0] pc_next,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              in_delay_slot,
    output logic              illegal,
    output logic              mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state_q;
    state_t            state_d;
    instr_class_t      cls;
    logic              is_br;
    logic              pending_q;
    logic [ADDR_W-1:0] target_q;
    logic              ds_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_last;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              take_branch;

    assign cls       = classify(opcode);
    assign is_br     = (cls == CLS_BR);
    assign wait_last = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    branch_resolver #(.ADDR_W(ADDR_W)) u_branch (
        .opcode   (opcode),
        .imm16    (imm16),
        .jidx     (jidx),
        .pc       (pc),
        .rs_eq_rt (rs_eq_rt),
        .rs_zero  (rs_zero),
        .rs_neg   (rs_neg),
        .taken    (br_taken),
        .target   (br_target)
    );

    assign state         = state_q;
    // Reset suppresses every output immediately so an aborted instruction writes nothing.
    assign in_delay_slot = ds_q & ~reset;
    assign pc_next       = reset ? '0 : (pending_q ? target_q : pc + ADDR_W'(4));

    // Next-state and strobe decode; reset overrides everything.
    always_comb begin
        state_d     = state_q;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        take_branch = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_write = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls == CLS_ILLEGAL) begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    // A branch in a delay slot is flagged but still walks the branch path as a NOP.
                    illegal = is_br & ds_q;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ALU:              state_d = ST_WB;
                    CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
                    CLS_BR: begin
                        pc_write    = 1'b1;
                        take_branch = br_taken & ~ds_q;
                        state_d     = ST_FETCH;
                    end
                    default:              state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_read  = (cls == CLS_LOAD);
                mem_write = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (wait_last) begin
                    mem_timeout = 1'b1;
                    pc_write    = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
        if (reset) begin
            state_d     = ST_FETCH;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            illegal     = 1'b0;
            mem_timeout = 1'b0;
            take_branch = 1'b0;
        end
    end

    // State, MEM wait counter, delay-slot flag and pending branch target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pending_q <= 1'b0;
            target_q  <= '0;
            wait_cnt  <= '0;
            ds_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == ST_MEM && state_d == ST_MEM) ? wait_cnt + WAIT_W'(1) : '0;
            if (pc_write) begin
                // Only a branch outside a delay slot opens a new delay slot.
                ds_q      <= is_br & ~ds_q;
                pending_q <= 1'b0;
            end
            if (take_branch) begin
                pending_q <= 1'b1;
                target_q  <= br_target;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed vector table,
// reset-abort sequence, and randomized instruction stream against an
// instruction-level reference model.
module tb_multicycle_sequencer;

    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 15;

    localparam int C_ALU   = 0;
    localparam int C_LOAD  = 1;
    localparam int C_STORE = 2;
    localparam int C_BR    = 3;
    localparam int C_ILL   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] pc;
    logic        rs_eq_rt, rs_zero, rs_neg, mem_ready;
    logic [2:0]  state;
    logic        ir_write, pc_write, reg_write, mem_read, mem_write;
    logic        in_delay_slot, illegal, mem_timeout;
    logic [31:0] pc_next;

    int checks = 0;
    int errors = 0;

    // reference model state (instruction granularity)
    logic        m_pending;
    logic [31:0] m_target;
    logic        m_ds;
    logic [31:0] m_pc;

    multicycle_sequencer #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .imm16         (imm16),
        .jidx          (jidx),
        .pc            (pc),
        .rs_eq_rt      (rs_eq_rt),
        .rs_zero       (rs_zero),
        .rs_neg        (rs_neg),
        .mem_ready     (mem_ready),
        .state         (state),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_next       (pc_next),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .in_delay_slot (in_delay_slot),
        .illegal       (illegal),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] outs();
        return {state, ir_write, pc_write, reg_write, mem_read, mem_write,
                in_delay_slot, illegal, mem_timeout};
    endfunction

    function automatic int cls_of(input logic [5:0] op);
        if (op inside {6'b000000, 6'b011100, 6'b001000, 6'b001001}) return C_ALU;
        if (op inside {6'b100011, 6'b100000, 6'b100100})            return C_LOAD;
        if (op inside {6'b101011, 6'b101000})                       return C_STORE;
        if (op inside {6'b000100, 6'b000001, 6'b000110, 6'b000111, 6'b000010}) return C_BR;
        return C_ILL;
    endfunction

    function automatic logic taken_ref(input logic [5:0] op, input logic eq,
                                       input logic zr, input logic ng);
        case (op)
            6'b000100: return eq;
            6'b000001: return zr;
            6'b000110: return zr || ng;
            6'b000111: return !zr && !ng;
            6'b000010: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] target_ref(input logic [5:0] op, input logic [31:0] pcv,
                                               input logic [15:0] imm, input logic [25:0] ji);
        logic [31:0] p4;
        int          off;
        p4  = pcv + 32'd4;
        off = int'($signed(imm));
        if (op == 6'b000010) return {p4[31:28], ji, 2'b00};
        return p4 + 32'(off * 4);
    endfunction

    task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Run one instruction from FETCH to its last cycle, checking every cycle.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [15:0] imm,
                             input logic [25:0] ji, input logic [31:0] pcv, input logic eq,
                             input logic zr, input logic ng, input int ready_at,
                             output logic [31:0] got_pc);
        int          c;
        int          path[$];
        int          nmem;
        int          memidx;
        logic        timed;
        logic        ds0;
        logic [31:0] exp_pc;
        logic [10:0] exp;
        c      = cls_of(op);
        ds0    = m_ds;
        timed  = 1'b0;
        got_pc = '0;
        path   = {0, 1};
        if (c != C_ILL) begin
            path.push_back(2);
            if (c == C_LOAD || c == C_STORE) begin
                timed = (ready_at < 1 || ready_at > MAX_WAIT);
                nmem  = timed ? MAX_WAIT : ready_at;
                for (int i = 0; i < nmem; i++) path.push_back(3);
                if (c == C_LOAD && !timed) path.push_back(4);
            end else if (c == C_ALU) begin
                path.push_back(4);
            end
        end
        exp_pc   = m_pending ? m_target : pcv + 32'd4;
        opcode   = op;
        imm16    = imm;
        jidx     = ji;
        pc       = pcv;
        rs_eq_rt = eq;
        rs_zero  = zr;
        rs_neg   = ng;
        memidx   = 0;
        for (int k = 0; k < path.size(); k++) begin
            if (path[k] == 3) begin
                memidx++;
                mem_ready = (memidx == ready_at);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            exp = {3'(path[k]), k == 0, k == path.size() - 1, path[k] == 4,
                   path[k] == 3 && c == C_LOAD, path[k] == 3 && c == C_STORE, ds0,
                   k == 1 && (c == C_ILL || (c == C_BR && ds0)),
                   k == path.size() - 1 && timed};
            check_vec($sformatf("%s.cyc%0d", tag, k), 32'(outs()), 32'(exp));
            if (k == path.size() - 1) begin
                got_pc = pc_next;
                check_vec({tag, ".pc_next"}, pc_next, exp_pc);
            end
            @(posedge clk);
            #1;
        end
        m_pending = 1'b0;
        if (c == C_BR && !ds0 && taken_ref(op, eq, zr, ng)) begin
            m_pending = 1'b1;
            m_target  = target_ref(op, pcv, imm, ji);
        end
        m_ds = (c == C_BR) && !ds0;
        m_pc = exp_pc;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [15:0] imm;
        logic [25:0] ji;
        logic [31:0] pcv;
        logic        eq, zr, ng;
        int          ready_at;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        tbl[16];
    logic [5:0]  ops[14];
    logic [31:0] got;

    initial begin
        tbl[0]  = '{6'b001001, 16'h0000, 26'h0,  32'h00, 1'b0, 1'b0, 1'b0, 0,  32'h04};  // ADDIU
        tbl[1]  = '{6'b100100, 16'h0000, 26'h0,  32'h04, 1'b0, 1'b0, 1'b0, 3,  32'h08};  // LBU, ready on 3rd MEM
        tbl[2]  = '{6'b101011, 16'h0000, 26'h0,  32'h08, 1'b0, 1'b0, 1'b0, 0,  32'h0C};  // SW, timeout
        tbl[3]  = '{6'b000111, 16'hFFFD, 26'h0,  32'h18, 1'b0, 1'b0, 1'b0, 0,  32'h1C};  // BGTZ taken
        tbl[4]  = '{6'b000000, 16'h0000, 26'h0,  32'h1C, 1'b0, 1'b0, 1'b0, 0,  32'h10};  // SLL delay slot
        tbl[5]  = '{6'b000100, 16'h0010, 26'h0,  32'h2C, 1'b0, 1'b0, 1'b0, 0,  32'h30};  // BEQ not taken
        tbl[6]  = '{6'b000000, 16'h0000, 26'h0,  32'h30, 1'b0, 1'b0, 1'b0, 0,  32'h34};  // delay slot
        tbl[7]  = '{6'b111111, 16'h0000, 26'h0,  32'h34, 1'b0, 1'b0, 1'b0, 0,  32'h38};  // illegal
        tbl[8]  = '{6'b000010, 16'h0000, 26'h40, 32'h38, 1'b0, 1'b0, 1'b0, 0,  32'h3C};  // J
        tbl[9]  = '{6'b000100, 16'h0020, 26'h0,  32'h3C, 1'b1, 1'b0, 1'b0, 0,  32'h100}; // BEQ in slot
        tbl[10] = '{6'b001000, 16'h0000, 26'h0,  32'h100, 1'b0, 1'b0, 1'b0, 0, 32'h104}; // ADDI
        tbl[11] = '{6'b100011, 16'h0000, 26'h0,  32'h104, 1'b0, 1'b0, 1'b0, 1, 32'h108}; // LW, ready at once
        tbl[12] = '{6'b000110, 16'h0004, 26'h0,  32'h108, 1'b0, 1'b0, 1'b1, 0, 32'h10C}; // BLEZ taken
        tbl[13] = '{6'b101000, 16'h0000, 26'h0,  32'h10C, 1'b0, 1'b0, 1'b0, 15, 32'h11C}; // SB, ready on last cycle
        tbl[14] = '{6'b000001, 16'h0008, 26'h0,  32'h11C, 1'b0, 1'b0, 1'b0, 0, 32'h120}; // REGIMM not taken
        tbl[15] = '{6'b100000, 16'h0000, 26'h0,  32'h120, 1'b0, 1'b0, 1'b0, 0, 32'h124}; // LB timeout in slot

        ops = '{6'b000000, 6'b011100, 6'b001000, 6'b001001, 6'b100011, 6'b100000, 6'b100100,
                6'b101011, 6'b101000, 6'b000100, 6'b000001, 6'b000110, 6'b000111, 6'b000010};

        reset = 1'b1; opcode = '0; imm16 = '0; jidx = '0; pc = '0;
        rs_eq_rt = 1'b0; rs_zero = 1'b0; rs_neg = 1'b0; mem_ready = 1'b0;
        m_pending = 1'b0; m_target = '0; m_ds = 1'b0; m_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_vec("reset.outs", 32'(outs()), 32'h0);
        check_vec("reset.pc_next", pc_next, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].imm, tbl[i].ji, tbl[i].pcv,
                      tbl[i].eq, tbl[i].zr, tbl[i].ng, tbl[i].ready_at, got);
            check_vec($sformatf("tbl%0d.expected_pc", i), got, tbl[i].exp_pc);
        end

        // Reset during MEM of a delay-slot load with a pending jump.
        run_instr("rst.j", 6'b000010, 16'h0, 26'h80, 32'h200, 1'b0, 1'b0, 1'b0, 0, got);
        opcode = 6'b100011; pc = 32'h204; mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) check_vec("rst.in_mem", 32'(state), 32'd3);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check_vec("rst.same_cycle", 32'(outs()), {21'b0, 3'd3, 8'b0});
        check_vec("rst.same_cycle_pc", pc_next, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_vec("rst.after", 32'(outs()), 32'h0);
        check_vec("rst.after_pc", pc_next, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pending = 1'b0;
        m_ds = 1'b0;
        run_instr("rst.addiu", 6'b001001, 16'h0, 26'h0, 32'h300, 1'b0, 1'b0, 1'b0, 0, got);
        check_vec("rst.addiu_pc", got, 32'h304);

        // Randomized instruction stream.
        m_pc = 32'h0000_1000;
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            int         sel;
            sel = $urandom_range(0, 15);
            op  = (sel < 14) ? ops[sel] : 6'($urandom);
            run_instr($sformatf("rnd%0d", n), op, 16'($urandom), 26'($urandom), m_pc,
                      1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 17), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
